// File: rtl/slurm32_alu_pkg.sv
// Shared definitions for the slurm32 ALU: opcode enumeration, flag-register
// bit positions and a helper deciding which opcodes write the flags.
// Optional feature macro: SLURM32_ALU_MUL_EN (enables MUL / MULU).
package slurm32_alu_pkg;

    typedef enum logic [4:0] {
        ALU_MOV   = 5'd0,
        ALU_ADD   = 5'd1,
        ALU_ADC   = 5'd2,
        ALU_SUB   = 5'd3,
        ALU_SBB   = 5'd4,
        ALU_AND   = 5'd5,
        ALU_OR    = 5'd6,
        ALU_XOR   = 5'd7,
        ALU_MUL   = 5'd8,
        ALU_MULU  = 5'd9,
        ALU_CMP   = 5'd10,
        ALU_TEST  = 5'd11,
        ALU_BSWAP = 5'd12,
        ALU_NOT   = 5'd13,
        ALU_ASR   = 5'd16,
        ALU_LSR   = 5'd17,
        ALU_LSL   = 5'd18,
        ALU_ROL   = 5'd19,
        ALU_ROR   = 5'd20,
        ALU_RLC   = 5'd21,
        ALU_RRC   = 5'd22
    } alu_op_e;

    // Bit positions inside the 4-bit flag register {V,S,Z,C}
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_S = 2;
    localparam int unsigned FLAG_V = 3;

    // True for opcodes that latch new flags on the clock edge
    function automatic logic op_updates_flags(input logic [4:0] op);
        logic upd;
        case (op)
            5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
            5'd10, 5'd11,
            5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22: upd = 1'b1;
`ifdef SLURM32_ALU_MUL_EN
            5'd8, 5'd9: upd = 1'b1;
`endif
            default: upd = 1'b0;
        endcase
        return upd;
    endfunction

endpackage

// File: rtl/slurm32_alu_shifter.sv
// Shift / rotate unit of the slurm32 ALU. Produces the shifted value and the
// last bit shifted out; a zero shift amount passes the incoming carry through
// so the flag is effectively held. RLC/RRC always rotate by exactly one bit
// through the carry and ignore the amount.
module slurm32_alu_shifter
    import slurm32_alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [4:0]  amount,
    input  logic [4:0]  op,
    input  logic        c_in,
    output logic [31:0] result,
    output logic        carry_out
);

    logic [32:0] lsl_ext_s;
    logic [32:0] lsr_ext_s;
    logic [32:0] asr_ext_s;
    logic [63:0] rol_ext_s;
    logic [63:0] ror_ext_s;
    logic        amount_zero_s;

    // Extended vectors keep the last shifted-out bit next to the result
    assign lsl_ext_s     = {1'b0, a} << amount;
    assign lsr_ext_s     = {a, 1'b0} >> amount;
    assign asr_ext_s     = $signed({a, 1'b0}) >>> amount;
    assign rol_ext_s     = {a, a} << amount;
    assign ror_ext_s     = {a, a} >> amount;
    assign amount_zero_s = (amount == 5'd0);

    // Select the result and carry for the requested shift/rotate
    always_comb begin
        result    = 32'd0;
        carry_out = c_in;
        case (op)
            5'd16: begin
                result    = asr_ext_s[32:1];
                carry_out = amount_zero_s ? c_in : asr_ext_s[0];
            end
            5'd17: begin
                result    = lsr_ext_s[32:1];
                carry_out = amount_zero_s ? c_in : lsr_ext_s[0];
            end
            5'd18: begin
                result    = lsl_ext_s[31:0];
                carry_out = amount_zero_s ? c_in : lsl_ext_s[32];
            end
            5'd19: begin
                result    = rol_ext_s[63:32];
                carry_out = amount_zero_s ? c_in : rol_ext_s[32];
            end
            5'd20: begin
                result    = ror_ext_s[31:0];
                carry_out = amount_zero_s ? c_in : ror_ext_s[31];
            end
            5'd21: begin
                result    = {a[30:0], c_in};
                carry_out = a[31];
            end
            5'd22: begin
                result    = {c_in, a[31:1]};
                carry_out = a[0];
            end
            default: begin
                result    = 32'd0;
                carry_out = c_in;
            end
        endcase
    end

endmodule

// File: rtl/slurm32_cpu_alu.sv
// slurm32 CPU ALU: combinational 32-bit result plus registered C/Z/S/V flags.
// Flags can be force-loaded from the *_in inputs, which beats any opcode
// update in the same cycle. CMP/TEST set flags from the internal difference
// or AND while passing A through to the output.
// Optional feature macro: SLURM32_ALU_MUL_EN (enables MUL / MULU; otherwise
// opcodes 8 and 9 act as unused codes).
module slurm32_cpu_alu
    import slurm32_alu_pkg::*;
(
    input  logic        CLK,
    input  logic        RSTb,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  aluOp,
    output logic [31:0] aluOut,
    output logic        C,
    output logic        Z,
    output logic        S,
    output logic        V,
    input  logic        C_in,
    input  logic        Z_in,
    input  logic        S_in,
    input  logic        V_in,
    input  logic        load_flags
);

    alu_op_e     op_s;
    logic [3:0]  flags_r;
    logic [3:0]  next_flags_s;
    logic        adc_cin_s;
    logic        sbb_bin_s;
    logic [32:0] sum_s;
    logic [32:0] diff_s;
    logic [31:0] and_s;
    logic [31:0] alu_out_s;
    logic [31:0] flag_val_s;
    logic        carry_s;
    logic        ovf_s;
    logic [31:0] shift_res_s;
    logic        shift_carry_s;
`ifdef SLURM32_ALU_MUL_EN
    logic [63:0] prod_s;
    assign prod_s = {32'd0, A} * {32'd0, B};
`endif

    assign op_s      = alu_op_e'(aluOp);
    assign adc_cin_s = (op_s == ALU_ADC) ? flags_r[FLAG_C] : 1'b0;
    assign sbb_bin_s = (op_s == ALU_SBB) ? flags_r[FLAG_C] : 1'b0;
    // Bit 32 of the difference is the borrow (A < B + borrow-in)
    assign sum_s     = {1'b0, A} + {1'b0, B} + {32'd0, adc_cin_s};
    assign diff_s    = {1'b0, A} - {1'b0, B} - {32'd0, sbb_bin_s};
    assign and_s     = A & B;

    slurm32_alu_shifter u_shifter (
        .a         (A),
        .amount    (B[4:0]),
        .op        (aluOp),
        .c_in      (flags_r[FLAG_C]),
        .result    (shift_res_s),
        .carry_out (shift_carry_s)
    );

    // Result mux plus the value/carry/overflow candidates for the flag update
    always_comb begin
        alu_out_s  = 32'd0;
        flag_val_s = 32'd0;
        carry_s    = flags_r[FLAG_C];
        ovf_s      = flags_r[FLAG_V];
        case (op_s)
            ALU_MOV:   alu_out_s = B;
            ALU_ADD, ALU_ADC: begin
                alu_out_s  = sum_s[31:0];
                flag_val_s = sum_s[31:0];
                carry_s    = sum_s[32];
                ovf_s      = (A[31] == B[31]) && (sum_s[31] != A[31]);
            end
            ALU_SUB, ALU_SBB, ALU_CMP: begin
                alu_out_s  = (op_s == ALU_CMP) ? A : diff_s[31:0];
                flag_val_s = diff_s[31:0];
                carry_s    = diff_s[32];
                ovf_s      = (A[31] != B[31]) && (diff_s[31] != A[31]);
            end
            ALU_AND: begin
                alu_out_s  = and_s;
                flag_val_s = and_s;
            end
            ALU_TEST: begin
                alu_out_s  = A;
                flag_val_s = and_s;
            end
            ALU_OR: begin
                alu_out_s  = A | B;
                flag_val_s = A | B;
            end
            ALU_XOR: begin
                alu_out_s  = A ^ B;
                flag_val_s = A ^ B;
            end
`ifdef SLURM32_ALU_MUL_EN
            ALU_MUL: begin
                alu_out_s  = prod_s[31:0];
                flag_val_s = prod_s[31:0];
            end
            ALU_MULU: begin
                alu_out_s  = prod_s[63:32];
                flag_val_s = prod_s[63:32];
            end
`endif
            ALU_BSWAP: alu_out_s = {B[7:0], B[15:8], B[23:16], B[31:24]};
            ALU_NOT:   alu_out_s = ~B;
            ALU_ASR, ALU_LSR, ALU_LSL, ALU_ROL, ALU_ROR, ALU_RLC, ALU_RRC: begin
                alu_out_s  = shift_res_s;
                flag_val_s = shift_res_s;
                carry_s    = shift_carry_s;
            end
            default:   alu_out_s = 32'd0;
        endcase
    end

    assign aluOut = alu_out_s;

    // Next flag value: external load first, then opcode update, else hold
    always_comb begin
        next_flags_s = flags_r;
        if (load_flags) begin
            next_flags_s[FLAG_C] = C_in;
            next_flags_s[FLAG_Z] = Z_in;
            next_flags_s[FLAG_S] = S_in;
            next_flags_s[FLAG_V] = V_in;
        end else if (op_updates_flags(aluOp)) begin
            next_flags_s[FLAG_C] = carry_s;
            next_flags_s[FLAG_Z] = (flag_val_s == 32'd0);
            next_flags_s[FLAG_S] = flag_val_s[31];
            next_flags_s[FLAG_V] = ovf_s;
        end else begin
            next_flags_s = flags_r;
        end
    end

    // Flag register, cleared asynchronously by reset
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            flags_r <= 4'd0;
        end else begin
            flags_r <= next_flags_s;
        end
    end

    assign C = flags_r[FLAG_C];
    assign Z = flags_r[FLAG_Z];
    assign S = flags_r[FLAG_S];
    assign V = flags_r[FLAG_V];

endmodule

// File: tb/tb_slurm32_cpu_alu.sv
// Bench for slurm32_cpu_alu: directed vector table, hand sequences for the
// flag load and asynchronous reset, then random stimulus against a
// behavioural model. Flags are compared as the 4-bit value {V,S,Z,C}.
module tb_slurm32_cpu_alu;

    logic        CLK = 1'b0;
    logic        RSTb;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  aluOp;
    logic [31:0] aluOut;
    logic        C, Z, S, V;
    logic        C_in, Z_in, S_in, V_in;
    logic        load_flags;

    int total = 0;
    int bad   = 0;
    logic [3:0] mflags;

    slurm32_cpu_alu dut (
        .CLK        (CLK),
        .RSTb       (RSTb),
        .A          (A),
        .B          (B),
        .aluOp      (aluOp),
        .aluOut     (aluOut),
        .C          (C),
        .Z          (Z),
        .S          (S),
        .V          (V),
        .C_in       (C_in),
        .Z_in       (Z_in),
        .S_in       (S_in),
        .V_in       (V_in),
        .load_flags (load_flags)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  pre;
        logic [31:0] eout;
        logic [3:0]  ef;
    } vec_t;

    vec_t vecs[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got VSZC=%b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [3:0] dut_flags();
        return {V, S, Z, C};
    endfunction

    // Behavioural reference: arithmetic on wide integers, shifts one bit at a time
    function automatic void ref_calc(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [3:0] fin,
                                     output logic [31:0] out, output logic [3:0] fout);
        longint     sa, sb, sr;
        bit [63:0]  ur, ci;
        bit [31:0]  v, fv;
        bit         cy, upd;
        int         n;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        fout = fin;
        out = 32'd0;
        fv = 32'd0;
        upd = 1'b0;
        cy = fin[0];
        ci = 64'd0;
        case (op)
            5'd0: out = b;
            5'd1, 5'd2: begin
                if (op == 5'd2) ci = 64'(fin[0]);
                ur = {32'd0, a} + {32'd0, b} + ci;
                out = ur[31:0]; fv = out; cy = ur[32];
                sr = sa + sb + longint'(ci);
                fout[3] = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
                upd = 1'b1;
            end
            5'd3, 5'd4, 5'd10: begin
                if (op == 5'd4) ci = 64'(fin[0]);
                fv = a - b - ci[31:0];
                cy = ({32'd0, a} < ({32'd0, b} + ci));
                sr = sa - sb - longint'(ci);
                fout[3] = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
                out = (op == 5'd10) ? a : fv;
                upd = 1'b1;
            end
            5'd5:  begin fv = a & b; out = fv; upd = 1'b1; end
            5'd6:  begin fv = a | b; out = fv; upd = 1'b1; end
            5'd7:  begin fv = a ^ b; out = fv; upd = 1'b1; end
            5'd11: begin fv = a & b; out = a;  upd = 1'b1; end
`ifdef SLURM32_ALU_MUL_EN
            5'd8, 5'd9: begin
                ur = {32'd0, a} * {32'd0, b};
                fv = (op == 5'd8) ? ur[31:0] : ur[63:32];
                out = fv; upd = 1'b1;
            end
`endif
            5'd12: out = {b[7:0], b[15:8], b[23:16], b[31:24]};
            5'd13: out = ~b;
            5'd16, 5'd17, 5'd18, 5'd19, 5'd20: begin
                v = a;
                n = int'(b[4:0]);
                for (int i = 0; i < n; i++) begin
                    case (op)
                        5'd16: begin cy = v[0];  v = {v[31], v[31:1]}; end
                        5'd17: begin cy = v[0];  v = v >> 1; end
                        5'd18: begin cy = v[31]; v = v << 1; end
                        5'd19: begin cy = v[31]; v = {v[30:0], v[31]}; end
                        default: begin cy = v[0]; v = {v[0], v[31:1]}; end
                    endcase
                end
                out = v; fv = v; upd = 1'b1;
            end
            5'd21: begin out = {a[30:0], fin[0]}; cy = a[31]; fv = out; upd = 1'b1; end
            5'd22: begin out = {fin[0], a[31:1]}; cy = a[0];  fv = out; upd = 1'b1; end
            default: out = 32'd0;
        endcase
        if (upd) begin
            fout[0] = cy;
            fout[1] = (fv == 32'd0);
            fout[2] = fv[31];
        end
    endfunction

    task automatic load_pre(input logic [3:0] pre);
        @(negedge CLK);
        load_flags = 1'b1;
        {V_in, S_in, Z_in, C_in} = pre;
        aluOp = 5'd1; A = $urandom; B = $urandom;
        @(posedge CLK); #1;
        check4("preload", dut_flags(), pre);
        mflags = pre;
        load_flags = 1'b0;
    endtask

    task automatic rand_step();
        logic [31:0] eout;
        logic [3:0]  ef;
        logic        ld;
        logic [3:0]  ldv;
        int          sel;
        @(negedge CLK);
        aluOp = 5'($urandom_range(0, 31));
        sel = $urandom_range(0, 5);
        case (sel)
            0: A = 32'hFFFF_FFFF;
            1: A = 32'h8000_0000;
            2: A = 32'h7FFF_FFFF;
            3: A = 32'd0;
            default: A = $urandom;
        endcase
        B = ($urandom_range(0, 7) == 0) ? A : $urandom;
        ld = ($urandom_range(0, 9) == 0);
        ldv = 4'($urandom_range(0, 15));
        load_flags = ld;
        {V_in, S_in, Z_in, C_in} = ldv;
        #1;
        ref_calc(aluOp, A, B, mflags, eout, ef);
        check32("rand_out", aluOut, eout);
        @(posedge CLK); #1;
        mflags = ld ? ldv : ef;
        check4("rand_flags", dut_flags(), mflags);
        load_flags = 1'b0;
    endtask

    initial begin
        RSTb = 1'b0; A = 32'd0; B = 32'd0; aluOp = 5'd0;
        {C_in, Z_in, S_in, V_in} = 4'd0; load_flags = 1'b0;
        mflags = 4'd0;

        vecs.push_back('{5'd1,  32'd3,          32'd4,          4'b0000, 32'd7,          4'b0000});
        vecs.push_back('{5'd1,  32'hFFFF_FFFF,  32'd1,          4'b0000, 32'd0,          4'b0011});
        vecs.push_back('{5'd1,  32'h7FFF_FFFF,  32'd1,          4'b0000, 32'h8000_0000,  4'b1100});
        vecs.push_back('{5'd3,  32'd1,          32'd2,          4'b0000, 32'hFFFF_FFFF,  4'b0101});
        vecs.push_back('{5'd10, 32'd5,          32'd5,          4'b0001, 32'd5,          4'b0010});
        vecs.push_back('{5'd2,  32'd1,          32'd1,          4'b0001, 32'd3,          4'b0000});
        vecs.push_back('{5'd18, 32'h8000_0001,  32'd1,          4'b0000, 32'd2,          4'b0001});
        vecs.push_back('{5'd0,  32'd9,          32'h0000_1234,  4'b1111, 32'h0000_1234,  4'b1111});
        vecs.push_back('{5'd12, 32'd0,          32'h1122_3344,  4'b0101, 32'h4433_2211,  4'b0101});
        vecs.push_back('{5'd13, 32'd7,          32'd0,          4'b1010, 32'hFFFF_FFFF,  4'b1010});
        vecs.push_back('{5'd14, 32'd5,          32'd6,          4'b0011, 32'd0,          4'b0011});
        vecs.push_back('{5'd17, 32'h8000_0000,  32'd0,          4'b1001, 32'h8000_0000,  4'b1101});
        vecs.push_back('{5'd11, 32'h0000_00F0,  32'h0000_000F,  4'b1001, 32'h0000_00F0,  4'b1011});
        vecs.push_back('{5'd4,  32'd0,          32'd0,          4'b0001, 32'hFFFF_FFFF,  4'b0101});
        vecs.push_back('{5'd22, 32'd1,          32'd0,          4'b0001, 32'h8000_0000,  4'b0101});
        vecs.push_back('{5'd16, 32'h8000_0000,  32'd31,         4'b0001, 32'hFFFF_FFFF,  4'b0100});
`ifdef SLURM32_ALU_MUL_EN
        vecs.push_back('{5'd8,  32'h0001_0000,  32'h0001_0000,  4'b0000, 32'd0,          4'b0010});
        vecs.push_back('{5'd9,  32'h0001_0000,  32'h0001_0000,  4'b0011, 32'd1,          4'b0001});
`else
        vecs.push_back('{5'd8,  32'h0001_0000,  32'h0001_0000,  4'b0000, 32'd0,          4'b0000});
        vecs.push_back('{5'd9,  32'h0001_0000,  32'h0001_0000,  4'b0011, 32'd0,          4'b0011});
`endif

        // Reset state
        #12;
        check4("reset_flags", dut_flags(), 4'b0000);
        @(negedge CLK);
        RSTb = 1'b1;

        // Directed vectors
        for (int i = 0; i < vecs.size(); i++) begin
            load_pre(vecs[i].pre);
            @(negedge CLK);
            aluOp = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
            #1;
            check32($sformatf("vec%0d_out", i), aluOut, vecs[i].eout);
            @(posedge CLK); #1;
            check4($sformatf("vec%0d_flags", i), dut_flags(), vecs[i].ef);
            mflags = vecs[i].ef;
        end

        // Flag load beats an ADD in the same cycle
        load_pre(4'b0000);
        @(negedge CLK);
        aluOp = 5'd1; A = 32'd3; B = 32'd4;
        load_flags = 1'b1; C_in = 1'b1; Z_in = 1'b0; S_in = 1'b1; V_in = 1'b1;
        #1;
        check32("load_prio_out", aluOut, 32'd7);
        @(posedge CLK); #1;
        check4("load_prio_flags", dut_flags(), 4'b1101);
        load_flags = 1'b0;
        mflags = 4'b1101;

        // Asynchronous reset between edges, then a normal update after release
        load_pre(4'b1111);
        @(negedge CLK);
        aluOp = 5'd1; A = 32'hFFFF_FFFF; B = 32'd1;
        #1 RSTb = 1'b0;
        #1;
        check4("async_reset", dut_flags(), 4'b0000);
        #1 RSTb = 1'b1;
        mflags = 4'b0000;
        @(posedge CLK); #1;
        check4("post_reset_update", dut_flags(), 4'b0011);
        mflags = 4'b0011;

        // Random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            rand_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
